// File: rtl/ex_mem_stage_mc.sv
// EX/MEM pipeline register with a multi-cycle (MUL/DIV) holding FSM.
// Payload is parked while the unit computes; a bubble is issued meanwhile.
module ex_mem_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int WB_W    = 2,
  parameter int MEM_W   = 2,
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_reg,
  input  logic              flush,
  input  logic              mc_start,
  input  logic [1:0]        mc_op,
  input  logic [DATA_W-1:0] mc_result,
  input  logic              valid_in,
  input  logic [WB_W-1:0]   WB_in,
  input  logic [MEM_W-1:0]  MEM_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [REG_W-1:0]  WN_in,
  output logic              valid_out,
  output logic [WB_W-1:0]   WB_out,
  output logic [MEM_W-1:0]  MEM_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] RD2_out,
  output logic [REG_W-1:0]  WN_out,
  output logic              busy,
  output logic              mc_done
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINISH
  } state_t;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  state_t             state;
  logic [7:0]         cnt;
  logic               h_valid;
  logic [WB_W-1:0]    h_wb;
  logic [MEM_W-1:0]   h_mem;
  logic [DATA_W-1:0]  h_rd2;
  logic [REG_W-1:0]   h_wn;
  logic               is_mc;

  assign is_mc = mc_start && (mc_op == 2'b01 || mc_op == 2'b10);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      h_valid   <= 1'b0;
      h_wb      <= '0;
      h_mem     <= '0;
      h_rd2     <= '0;
      h_wn      <= '0;
      valid_out <= 1'b0;
      WB_out    <= '0;
      MEM_out   <= '0;
      alu_out   <= '0;
      RD2_out   <= '0;
      WN_out    <= '0;
      mc_done   <= 1'b0;
    end else begin
      mc_done <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        cnt       <= '0;
        h_valid   <= 1'b0;
        valid_out <= 1'b0;
        WB_out    <= '0;
        MEM_out   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (en_reg) begin
              if (is_mc) begin
                h_valid   <= valid_in;
                h_wb      <= WB_in;
                h_mem     <= MEM_in;
                h_rd2     <= RD2_in;
                h_wn      <= WN_in;
                cnt       <= (mc_op == 2'b01) ? MUL_CNT : DIV_CNT;
                valid_out <= 1'b0;
                WB_out    <= '0;
                MEM_out   <= '0;
                state     <= BUSY;
              end else begin
                valid_out <= valid_in;
                WB_out    <= WB_in;
                MEM_out   <= MEM_in;
                alu_out   <= alu_in;
                RD2_out   <= RD2_in;
                WN_out    <= WN_in;
              end
            end
          end
          BUSY: begin
            // Counter stops at zero; the next edge is the write-back edge.
            if (cnt == 8'd0) state <= FINISH;
            else             cnt   <= cnt - 8'd1;
          end
          FINISH: begin
            valid_out <= h_valid;
            WB_out    <= h_wb;
            MEM_out   <= h_mem;
            alu_out   <= mc_result;
            RD2_out   <= h_rd2;
            WN_out    <= h_wn;
            mc_done   <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_mc.sv
// Randomized bench for ex_mem_stage_mc against a countdown reference model.
// Covers plain passes, MUL/DIV latency, flush, en_reg hold and async reset.
module tb_ex_mem_stage_mc;

  localparam int MUL = 32;
  localparam int DIV = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_reg, flush, mc_start;
  logic [1:0]  mc_op;
  logic [31:0] mc_result;
  logic        valid_in;
  logic [1:0]  WB_in, MEM_in;
  logic [31:0] alu_in, RD2_in;
  logic [4:0]  WN_in;
  logic        valid_out;
  logic [1:0]  WB_out, MEM_out;
  logic [31:0] alu_out, RD2_out;
  logic [4:0]  WN_out;
  logic        busy, mc_done;

  ex_mem_stage_mc #(
    .DATA_W(32), .WB_W(2), .MEM_W(2), .REG_W(5),
    .MUL_LAT(MUL), .DIV_LAT(DIV)
  ) dut (
    .clk(clk), .rst(rst), .en_reg(en_reg), .flush(flush),
    .mc_start(mc_start), .mc_op(mc_op), .mc_result(mc_result),
    .valid_in(valid_in), .WB_in(WB_in), .MEM_in(MEM_in),
    .alu_in(alu_in), .RD2_in(RD2_in), .WN_in(WN_in),
    .valid_out(valid_out), .WB_out(WB_out), .MEM_out(MEM_out),
    .alu_out(alu_out), .RD2_out(RD2_out), .WN_out(WN_out),
    .busy(busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: expected outputs plus the number of edges left until
  // a parked multi-cycle result is written (0 = nothing in flight).
  logic        e_valid, e_done;
  logic [1:0]  e_wb, e_mem;
  logic [31:0] e_alu, e_rd2;
  logic [4:0]  e_wn;
  int          left;
  logic        p_valid;
  logic [1:0]  p_wb, p_mem;
  logic [31:0] p_rd2;
  logic [4:0]  p_wn;
  int          starts = 0;
  int          dones = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_done = 0; e_wb = 0; e_mem = 0;
    e_alu = 0; e_rd2 = 0; e_wn = 0; left = 0;
    p_valid = 0; p_wb = 0; p_mem = 0; p_rd2 = 0; p_wn = 0;
  endtask

  task automatic model_edge();
    e_done = 0;
    if (flush) begin
      e_valid = 0; e_wb = 0; e_mem = 0; left = 0;
    end else if (left > 0) begin
      if (left == 1) begin
        e_valid = p_valid; e_wb = p_wb; e_mem = p_mem;
        e_rd2 = p_rd2; e_wn = p_wn; e_alu = mc_result;
        e_done = 1;
        dones++;
      end
      left--;
    end else if (en_reg) begin
      if (mc_start && (mc_op == 2'b01 || mc_op == 2'b10)) begin
        p_valid = valid_in; p_wb = WB_in; p_mem = MEM_in;
        p_rd2 = RD2_in; p_wn = WN_in;
        left = ((mc_op == 2'b01) ? MUL : DIV) + 1;
        e_valid = 0; e_wb = 0; e_mem = 0;
        starts++;
      end else begin
        e_valid = valid_in; e_wb = WB_in; e_mem = MEM_in;
        e_alu = alu_in; e_rd2 = RD2_in; e_wn = WN_in;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".valid"}, 64'(valid_out), 64'(e_valid));
    chk({ph, ".wb"}, 64'(WB_out), 64'(e_wb));
    chk({ph, ".mem"}, 64'(MEM_out), 64'(e_mem));
    chk({ph, ".alu"}, 64'(alu_out), 64'(e_alu));
    chk({ph, ".rd2"}, 64'(RD2_out), 64'(e_rd2));
    chk({ph, ".wn"}, 64'(WN_out), 64'(e_wn));
    chk({ph, ".busy"}, 64'(busy), 64'(left > 0));
    chk({ph, ".done"}, 64'(mc_done), 64'(e_done));
  endtask

  task automatic drive_idle();
    en_reg = 0; flush = 0; mc_start = 0; mc_op = 0;
    mc_result = 0; valid_in = 0; WB_in = 0; MEM_in = 0;
    alu_in = 0; RD2_in = 0; WN_in = 0;
  endtask

  task automatic step_check(input string ph);
    @(posedge clk);
    model_edge();
    #1 check_all(ph);
  endtask

  initial begin
    drive_idle();
    rst = 0;
    model_reset();
    #2 check_all("reset");
    @(negedge clk) rst = 1;

    // Plain pass
    @(negedge clk);
    en_reg = 1; valid_in = 1; WB_in = 2'b10; alu_in = 32'h1234; WN_in = 5;
    step_check("plain");

    // MUL with result DEAD_BEEF, destination 7
    @(negedge clk);
    mc_start = 1; mc_op = 2'b01; WN_in = 7; mc_result = 32'hDEAD_BEEF;
    step_check("mul_start");
    mc_start = 0;
    for (int i = 0; i < MUL + 1; i++) step_check("mul_run");
    chk("mul_wn", 64'(WN_out), 64'd7);
    chk("mul_res", 64'(alu_out), 64'hDEAD_BEEF);
    step_check("mul_after");

    // DIV with latency 1
    @(negedge clk);
    mc_start = 1; mc_op = 2'b10; mc_result = 32'h0000_00AB;
    step_check("div_start");
    mc_start = 0;
    step_check("div_fin");
    step_check("div_res");
    chk("div_res_alu", 64'(alu_out), 64'hAB);

    // Async reset mid-BUSY
    @(negedge clk);
    mc_start = 1; mc_op = 2'b01; WN_in = 9;
    step_check("rmul_start");
    mc_start = 0;
    step_check("rmul_run");
    rst = 0;
    model_reset();
    #1 check_all("rst_mid");
    #2 rst = 1;
    #0.5 check_all("rst_rel");

    // Randomized traffic with occasional flush and reset pulses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      en_reg    = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      mc_start  = ($urandom_range(0, 3) == 0);
      mc_op     = 2'($urandom_range(0, 3));
      mc_result = $urandom;
      valid_in  = 1'($urandom);
      WB_in     = 2'($urandom);
      MEM_in    = 2'($urandom);
      alu_in    = $urandom;
      RD2_in    = $urandom;
      WN_in     = 5'($urandom);
      step_check("rand");
      if ($urandom_range(0, 249) == 0) begin
        rst = 0;
        model_reset();
        #1 check_all("rand_rst");
        #2 rst = 1;
      end
    end

    chk("starts_seen", 64'(starts > 20), 64'd1);
    chk("dones_seen", 64'(dones > 5), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
